// File: rtl/uart_rx.sv
// 8N1 UART receiver with a show-ahead receive FIFO.
// Frames are sampled mid-bit from a synchronized copy of the serial line.
module uart_rx #(
  parameter int UART_CLOCK_HZ = 20_000_000,
  parameter int UART_BAUD     = 115200,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_error,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = UART_CLOCK_HZ / UART_BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2:0]     idx;
  logic [7:0]     sh;
  logic           s1;
  logic           s2;
  logic           rxs;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;
  logic [AW:0]    count;

  logic           stop_hit;
  logic           push_req;
  logic           pop;
  logic           full;
  logic           push_ok;

  assign rxs      = s2;
  assign stop_hit = (state == STOP) && (cnt == CNT_BIT);
  assign push_req = stop_hit && rxs;
  assign rx_valid = (count != '0);
  assign rx_data  = mem[rp];
  assign pop      = rx_valid && rx_ready;
  assign full     = (count == CNT_FULL);
  assign push_ok  = push_req && (!full || pop);

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= uart_rx_pin;
      s2 <= s1;
    end
  end

  // Frame state machine with registered error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      sh          <= '0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            if (!rxs) begin
              cnt   <= '0;
              idx   <= '0;
              state <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_BIT) begin
            cnt <= '0;
            sh  <= {rxs, sh[7:1]};
            idx <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_BIT) begin
            cnt <= '0;
            if (rxs) begin
              overrun <= full && !pop;
              state   <= IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_HIGH: begin
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Receive FIFO: write on accepted push, advance head on pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wp] <= sh;
        wp      <= wp + AW'(1);
      end
      if (pop) begin
        rp <= rp + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level model plus directed scenarios.
// 10 clocks per bit, FIFO depth 4.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pin = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       overrun;

  uart_rx #(
    .UART_CLOCK_HZ(1_000_000),
    .UART_BAUD(100_000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .uart_rx_pin(pin),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_error(frame_error),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       at;
    logic [7:0] b;
    bit       good;
  } ev_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  ev_t        evq[$];
  logic [7:0] mq[$];
  logic [7:0] popped[$];
  ev_t        ev;
  bit         mpop;

  bit         exp_valid = 0;
  bit         exp_fe = 0;
  bit         exp_ov = 0;
  logic [7:0] exp_data = 0;

  int fe_cnt = 0;
  int ov_cnt = 0;
  int rise_cyc = 0;
  bit prev_valid = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Model: a frame whose pin falls after edge c resolves at edge c+98.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      exp_fe = 0;
      exp_ov = 0;
      if (reset) begin
        mq.delete();
        evq.delete();
      end else begin
        mpop = (mq.size() > 0) && rx_ready;
        if (mpop) void'(mq.pop_front());
        while (evq.size() > 0 && evq[0].at <= cyc) begin
          ev = evq.pop_front();
          if (ev.at == cyc) begin
            if (!ev.good) exp_fe = 1;
            else if (mq.size() < 4) mq.push_back(ev.b);
            else exp_ov = 1;
          end
        end
      end
      exp_valid = (mq.size() > 0);
      exp_data = exp_valid ? mq[0] : 8'h00;
    end
  end

  // Per-cycle compare against the model, plus event bookkeeping.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rx_valid", rx_valid, exp_valid);
        chk("frame_error", frame_error, exp_fe);
        chk("overrun", overrun, exp_ov);
        if (exp_valid) chk("rx_data", rx_data, exp_data);
        if (rx_valid && !prev_valid) rise_cyc = cyc;
        if (frame_error) fe_cnt++;
        if (overrun) ov_cnt++;
        if (rx_valid && rx_ready) popped.push_back(rx_data);
      end
      prev_valid = rx_valid;
    end
  end

  task automatic drive(input logic v, input int n);
    pin = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    drive(1'b1, n);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit stop_ok,
                           output int c);
    c = cyc;
    evq.push_back(ev_t'{at: c + 98, b: v, good: stop_ok});
    drive(1'b0, 10);
    for (int i = 0; i < 8; i++) drive(v[i], 10);
    drive(stop_ok, 10);
  endtask

  initial begin
    int c;
    int d;
    reset = 1'b1;
    pin = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", rx_valid, 0);
    chk("reset_fe", frame_error, 0);
    chk("reset_ov", overrun, 0);
    chk("reset_data", rx_data, 8'h00);
    reset = 1'b0;

    idle(200);
    chk("idle_fe_cnt", fe_cnt, 0);
    chk("idle_ov_cnt", ov_cnt, 0);
    chk("idle_pops", popped.size(), 0);

    rx_ready = 1'b1;
    send_byte(8'hA5, 1, c);
    idle(20);
    d = rise_cyc - c;
    chk("a5_latency_window", int'(d >= 98 && d <= 100), 1);
    chk("a5_pops", popped.size(), 1);
    chk("a5_byte", popped[0], 8'hA5);
    chk("a5_fe_cnt", fe_cnt, 0);

    drive(1'b0, 3);
    idle(30);
    chk("glitch_pops", popped.size(), 1);
    chk("glitch_fe_cnt", fe_cnt, 0);
    send_byte(8'h3C, 1, c);
    idle(20);
    chk("3c_byte", popped[1], 8'h3C);

    send_byte(8'h3C, 0, c);
    drive(1'b0, 40);
    idle(20);
    chk("ferr_fe_cnt", fe_cnt, 1);
    chk("ferr_pops", popped.size(), 2);
    send_byte(8'h81, 1, c);
    idle(20);
    chk("81_byte", popped[2], 8'h81);
    chk("81_fe_cnt", fe_cnt, 1);

    rx_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_byte(8'(k), 1, c);
    idle(10);
    chk("ovr_ov_cnt", ov_cnt, 1);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_head", rx_data, 8'h01);
    rx_ready = 1'b1;
    idle(4);
    chk("ovr_drained", rx_valid, 0);
    idle(6);
    chk("ovr_pops", popped.size(), 7);
    chk("ovr_b1", popped[3], 8'h01);
    chk("ovr_b2", popped[4], 8'h02);
    chk("ovr_b3", popped[5], 8'h03);
    chk("ovr_b4", popped[6], 8'h04);

    rx_ready = 1'b0;
    send_byte(8'h11, 1, c);
    idle(10);
    chk("pre_rst_valid", rx_valid, 1);
    drive(1'b0, 10);
    drive(1'b1, 35);
    reset = 1'b1;
    pin = 1'b1;
    mq.delete();
    evq.delete();
    #1;
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_fe", frame_error, 0);
    chk("mid_rst_ov", overrun, 0);
    chk("mid_rst_data", rx_data, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(20);
    chk("post_rst_valid", rx_valid, 0);
    rx_ready = 1'b1;
    send_byte(8'h5A, 1, c);
    idle(20);
    chk("5a_pops", popped.size(), 8);
    chk("5a_byte", popped[7], 8'h5A);
    chk("end_fe_cnt", fe_cnt, 1);
    chk("end_ov_cnt", ov_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
